// File: rtl/test_engine_nic_input_buffer_control_pkg.sv
// Shared definitions for the NiC input buffer control: defaults, write FSM states
// and a width helper.
package test_engine_nic_input_buffer_control_pkg;

    localparam int unsigned DEFAULT_DATA_FLITS = 4;

    typedef enum logic {
        W_IDLE    = 1'b0,
        W_CAPTURE = 1'b1
    } wr_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/test_engine_nic_input_buffer_control_if.sv
// Router-channel / PE / register-bank signal bundle of the NiC input buffer control.
interface test_engine_nic_input_buffer_control_if #(
    parameter int unsigned DATA_FLITS = 4,
    parameter int unsigned SLOT_W     = 1
);
    logic                  header_field_din;
    logic                  busy_engine_din;
    logic                  zero_credits_din;
    logic                  write_strobe_dout;
    logic [SLOT_W-1:0]     write_slot_dout;
    logic [DATA_FLITS:0]   register_enable_dout;
    logic                  transfer2pe_strobe_dout;
    logic [SLOT_W-1:0]     transfer_slot_dout;
    logic                  slot_release_dout;
    logic                  slots_full_dout;
    logic                  drop_error_dout;

    modport master (
        output header_field_din, busy_engine_din, zero_credits_din,
        input  write_strobe_dout, write_slot_dout, register_enable_dout,
               transfer2pe_strobe_dout, transfer_slot_dout, slot_release_dout,
               slots_full_dout, drop_error_dout
    );

    modport slave (
        input  header_field_din, busy_engine_din, zero_credits_din,
        output write_strobe_dout, write_slot_dout, register_enable_dout,
               transfer2pe_strobe_dout, transfer_slot_dout, slot_release_dout,
               slots_full_dout, drop_error_dout
    );
endinterface

// File: rtl/test_engine_nic_input_buffer_control_slot_tracker.sv
// Packet slot bookkeeping: valid bitmap, write/read pointers, post-transfer holdoff,
// full flag and release pulse.
module test_engine_nic_slot_tracker
    import test_engine_nic_input_buffer_control_pkg::*;
#(
    parameter int unsigned  NUM_SLOTS = 2,
    localparam int unsigned SLOT_W    = clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slot_complete,
    input  logic              transfer,
    output logic              head_valid,
    output logic [SLOT_W-1:0] rd_ptr,
    output logic [SLOT_W-1:0] wr_ptr,
    output logic              full,
    output logic              slot_release
);

    logic [NUM_SLOTS-1:0] valid;
    logic [NUM_SLOTS-1:0] valid_next;
    logic                 holdoff;

    always_comb begin
        valid_next = valid;
        if (slot_complete) valid_next[wr_ptr] = 1'b1;
        if (transfer)      valid_next[rd_ptr] = 1'b0;
    end

    assign head_valid   = valid[rd_ptr] & ~holdoff;
    // The holdoff cycle and the release pulse are the same cycle after a transfer.
    assign slot_release = holdoff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid   <= '0;
            full    <= 1'b0;
            holdoff <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            valid   <= valid_next;
            full    <= &valid_next;
            holdoff <= transfer;
            wr_ptr  <= wr_ptr + SLOT_W'(slot_complete);
            rd_ptr  <= rd_ptr + SLOT_W'(transfer);
        end
    end

endmodule

// File: rtl/test_engine_nic_input_buffer_control.sv
// NiC input buffer control: captures header+data packets into rotating slots and
// hands completed slots to the PE in arrival order.
module test_engine_nic_input_buffer_control
    import test_engine_nic_input_buffer_control_pkg::*;
#(
    parameter int unsigned  DATA_FLITS = DEFAULT_DATA_FLITS,
    parameter int unsigned  NUM_SLOTS  = 2,
    localparam int unsigned SLOT_W     = clog2(NUM_SLOTS)
) (
    input  logic clk,
    input  logic reset,
    test_engine_nic_input_buffer_control_if.slave bus
);

    localparam logic [DATA_FLITS:0] POS_FIRST = (DATA_FLITS + 1)'(1);

    wr_state_t           state;
    logic [DATA_FLITS:0] pos;
    logic                drop_error;
    logic                capturing;
    logic                accept;
    logic                slot_complete;
    logic                transfer;
    logic                head_valid;
    logic                full;
    logic                slot_release;
    logic                write_strobe;
    logic [SLOT_W-1:0]   rd_ptr;
    logic [SLOT_W-1:0]   wr_ptr;

    // Fullness is the registered flag, so a slot freed this cycle cannot take a header yet.
    assign capturing     = (state == W_CAPTURE);
    assign accept        = reset & ~capturing & bus.header_field_din & ~full;
    assign slot_complete = capturing & pos[DATA_FLITS];
    assign transfer      = head_valid & ~bus.busy_engine_din & ~bus.zero_credits_din;
    assign write_strobe  = accept | capturing;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= W_IDLE;
            pos        <= POS_FIRST;
            drop_error <= 1'b0;
        end else begin
            case (state)
                W_IDLE: begin
                    if (accept) begin
                        state <= W_CAPTURE;
                        pos   <= pos << 1;
                    end
                end
                W_CAPTURE: begin
                    if (pos[DATA_FLITS]) begin
                        state <= W_IDLE;
                        pos   <= POS_FIRST;
                    end else begin
                        pos <= pos << 1;
                    end
                end
                default: begin
                    state <= W_IDLE;
                    pos   <= POS_FIRST;
                end
            endcase
            if (~capturing & bus.header_field_din & full) drop_error <= 1'b1;
        end
    end

    test_engine_nic_slot_tracker #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_slot_tracker (
        .clk           (clk),
        .reset         (reset),
        .slot_complete (slot_complete),
        .transfer      (transfer),
        .head_valid    (head_valid),
        .rd_ptr        (rd_ptr),
        .wr_ptr        (wr_ptr),
        .full          (full),
        .slot_release  (slot_release)
    );

    assign bus.write_strobe_dout       = write_strobe;
    assign bus.write_slot_dout         = wr_ptr;
    assign bus.register_enable_dout    = write_strobe ? pos : '0;
    assign bus.transfer2pe_strobe_dout = transfer;
    assign bus.transfer_slot_dout      = rd_ptr;
    assign bus.slot_release_dout       = slot_release;
    assign bus.slots_full_dout         = full;
    assign bus.drop_error_dout         = drop_error;

endmodule
